// File: rtl/pkg_teclado.sv
// Shared definitions for the keypad code-entry sequencer.
//   - key-code constants produced by the matrix-keypad decoder
//   - sequencer state encoding
//   - registered status bundle driven to the access/actuator logic
//   - key classification helpers
package pkg_teclado;

    localparam logic [3:0] TECLA_CONFIRMA = 4'hA;
    localparam logic [3:0] TECLA_APAGA    = 4'hB;
    localparam logic [3:0] TECLA_LIMPA    = 4'hC;
    localparam logic [3:0] TECLA_NULA     = 4'hF;  // also the "empty slot" nibble

    typedef enum logic [2:0] {
        OCIOSO,
        ENTRADA,
        VERIFICAR,
        SUCESSO,
        FALHA,
        BLOQUEIO
    } estado_t;

    typedef struct packed {
        logic acesso_ok;
        logic acesso_negado;
        logic bloqueado;
        logic ocupado;
    } status_t;

    function automatic logic eh_digito(input logic [3:0] tecla);
        return tecla <= 4'd9;
    endfunction

    // 0xD..0xF carry no meaning: they neither edit nor refresh the idle timer
    function automatic logic eh_ignorada(input logic [3:0] tecla);
        return tecla > TECLA_LIMPA;
    endfunction

endpackage

// File: rtl/temporizador_ciclos.sv
// Up-counter with synchronous clear and terminal-count flag.
//   clk, rst  : clock / async active-high reset
//   limpa     : clear to zero (has priority over habilita)
//   habilita  : count one cycle
//   fim       : high while the count equals CICLOS-1
// The count saturates at CICLOS-1, so it can never wrap.
module temporizador_ciclos #(
    parameter int CICLOS = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic limpa,
    input  logic habilita,
    output logic fim
);

    localparam int W = (CICLOS > 1) ? $clog2(CICLOS) : 1;

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (limpa)
            cnt <= '0;
        else if (habilita && !fim)
            cnt <= cnt + W'(1);
    end

    assign fim = (cnt == W'(CICLOS - 1));

endmodule

// File: rtl/controlador_entrada_senha.sv
// Code-entry sequencer downstream of the keypad decoder.
// Assembles a NUM_DIGITOS-digit code from key events, handles confirm /
// backspace / clear, checks against senha_ref, enforces an idle timeout and
// a lockout after MAX_TENTATIVAS consecutive failures.
//
// Ports:
//   clk, rst       clock, async active-high reset
//   tecla_value    decoded key code (sampled on the rising edge of tecla_valid)
//   tecla_valid    high while a debounced key is held
//   senha_ref      reference code, last digit in [3:0]
//   digitos        entry buffer, newest digit in [3:0], empty nibbles = 4'hF
//   num_digitos    number of digits entered
//   acesso_ok      1-cycle pulse on a correct code
//   acesso_negado  1-cycle pulse on a wrong or incomplete code
//   bloqueado      high during lockout
//   ocupado        high whenever not idle
//
// Build option: define SENHA_MASCARADA_EN to show every entered digit as
// 4'hE on digitos (comparison still uses the real digits).
module controlador_entrada_senha
    import pkg_teclado::*;
#(
    parameter int NUM_DIGITOS     = 4,
    parameter int TIMEOUT_CICLOS  = 1000,
    parameter int MAX_TENTATIVAS  = 3,
    parameter int BLOQUEIO_CICLOS = 5000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [3:0]               tecla_value,
    input  logic                     tecla_valid,
    input  logic [4*NUM_DIGITOS-1:0] senha_ref,
    output logic [4*NUM_DIGITOS-1:0] digitos,
    output logic [3:0]               num_digitos,
    output logic                     acesso_ok,
    output logic                     acesso_negado,
    output logic                     bloqueado,
    output logic                     ocupado
);

    localparam int BW = 4 * NUM_DIGITOS;
    localparam int FW = $clog2(MAX_TENTATIVAS + 1);
    localparam logic [3:0]    CHEIO   = 4'(NUM_DIGITOS);
    localparam logic [BW-1:0] VAZIO   = {NUM_DIGITOS{TECLA_NULA}};
    localparam logic [FW-1:0] LIMITE  = FW'(MAX_TENTATIVAS);

    estado_t       estado, prox_estado;
    logic [BW-1:0] buffer, prox_buffer;
    logic [3:0]    contagem, prox_contagem;
    logic [FW-1:0] falhas, prox_falhas;
    status_t       status;

    logic tecla_q;
    logic evento;
    logic evento_util;
    logic fim_ocioso;
    logic fim_bloqueio;

    // Written via a wide temporary so the slices stay legal for NUM_DIGITOS=1
    function automatic logic [BW-1:0] entra_digito(input logic [BW-1:0] b,
                                                   input logic [3:0]    d);
        logic [BW+3:0] t;
        t = {b, d};
        return t[BW-1:0];
    endfunction

    function automatic logic [BW-1:0] apaga_digito(input logic [BW-1:0] b);
        logic [BW+3:0] t;
        t = {TECLA_NULA, b};
        return t[BW+3:4];
    endfunction

    // Rising-edge detector: one event per press, however long it is held.
    // Runs in every state; an edge seen where keys are ignored is simply lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            tecla_q <= 1'b0;
        else
            tecla_q <= tecla_valid;
    end

    assign evento      = tecla_valid && !tecla_q;
    assign evento_util = evento && !eh_ignorada(tecla_value);

    temporizador_ciclos #(.CICLOS(TIMEOUT_CICLOS)) u_tmr_ocioso (
        .clk      (clk),
        .rst      (rst),
        .limpa    ((estado != ENTRADA) || evento_util),
        .habilita (estado == ENTRADA),
        .fim      (fim_ocioso)
    );

    // Held at zero outside BLOQUEIO, so it is freshly loaded on entry
    temporizador_ciclos #(.CICLOS(BLOQUEIO_CICLOS)) u_tmr_bloqueio (
        .clk      (clk),
        .rst      (rst),
        .limpa    (estado != BLOQUEIO),
        .habilita (estado == BLOQUEIO),
        .fim      (fim_bloqueio)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado   <= OCIOSO;
            buffer   <= VAZIO;
            contagem <= '0;
            falhas   <= '0;
        end else begin
            estado   <= prox_estado;
            buffer   <= prox_buffer;
            contagem <= prox_contagem;
            falhas   <= prox_falhas;
        end
    end

    always_comb begin
        prox_estado   = estado;
        prox_buffer   = buffer;
        prox_contagem = contagem;
        prox_falhas   = falhas;

        case (estado)
            OCIOSO: begin
                if (evento) begin
                    if (eh_digito(tecla_value)) begin
                        prox_buffer   = entra_digito(VAZIO, tecla_value);
                        prox_contagem = 4'd1;
                        prox_estado   = ENTRADA;
                    end else if (tecla_value == TECLA_CONFIRMA) begin
                        prox_estado = FALHA;
                    end
                end
            end

            ENTRADA: begin
                // A key event wins over a timeout landing in the same cycle
                if (evento_util) begin
                    if (eh_digito(tecla_value)) begin
                        if (contagem < CHEIO) begin
                            prox_buffer   = entra_digito(buffer, tecla_value);
                            prox_contagem = contagem + 4'd1;
                        end
                    end else if (tecla_value == TECLA_APAGA) begin
                        // contagem >= 1 is guaranteed while in ENTRADA
                        prox_buffer   = apaga_digito(buffer);
                        prox_contagem = contagem - 4'd1;
                        if (contagem == 4'd1)
                            prox_estado = OCIOSO;
                    end else if (tecla_value == TECLA_LIMPA) begin
                        prox_buffer   = VAZIO;
                        prox_contagem = '0;
                        prox_estado   = OCIOSO;
                    end else begin
                        prox_estado = VERIFICAR;
                    end
                end else if (fim_ocioso) begin
                    prox_buffer   = VAZIO;
                    prox_contagem = '0;
                    prox_estado   = OCIOSO;
                end
            end

            VERIFICAR: begin
                if ((contagem == CHEIO) && (buffer == senha_ref))
                    prox_estado = SUCESSO;
                else
                    prox_estado = FALHA;
            end

            SUCESSO: begin
                prox_buffer   = VAZIO;
                prox_contagem = '0;
                prox_falhas   = '0;
                prox_estado   = OCIOSO;
            end

            FALHA: begin
                prox_buffer   = VAZIO;
                prox_contagem = '0;
                prox_falhas   = falhas + FW'(1);
                if ((falhas + FW'(1)) == LIMITE)
                    prox_estado = BLOQUEIO;
                else
                    prox_estado = OCIOSO;
            end

            BLOQUEIO: begin
                if (fim_bloqueio) begin
                    prox_falhas = '0;
                    prox_estado = OCIOSO;
                end
            end

            default: begin
                prox_buffer   = VAZIO;
                prox_contagem = '0;
                prox_falhas   = '0;
                prox_estado   = OCIOSO;
            end
        endcase
    end

    // Status flags decoded from the current state, registered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            status <= '0;
        end else begin
            status.acesso_ok     <= (estado == SUCESSO);
            status.acesso_negado <= (estado == FALHA);
            status.bloqueado     <= (estado == BLOQUEIO);
            status.ocupado       <= (estado != OCIOSO);
        end
    end

    assign acesso_ok     = status.acesso_ok;
    assign acesso_negado = status.acesso_negado;
    assign bloqueado     = status.bloqueado;
    assign ocupado       = status.ocupado;
    assign num_digitos   = contagem;

`ifdef SENHA_MASCARADA_EN
    // Occupied slots are exactly the low contagem nibbles
    always_comb begin
        digitos = buffer;
        for (int i = 0; i < NUM_DIGITOS; i++) begin
            if (4'(i) < contagem)
                digitos[4*i +: 4] = 4'hE;
        end
    end
`else
    assign digitos = buffer;
`endif

endmodule

// File: doc/controlador_entrada_senha.md
Name: controlador_entrada_senha

Overview:
- Sequencer that sits downstream of the matrix-keypad decoder. It consumes the decoder's tecla_value/tecla_valid pair and assembles a NUM_DIGITOS-digit code.
- Handles the edit keys (confirm, backspace, clear) and compares the code against a reference.
- Enforces an inactivity timeout and a lockout after repeated failures.
- Drives pass/fail pulses and lock status to the access/actuator logic.

Parameters:
- NUM_DIGITOS, 4, digits per code (1..8).
- TIMEOUT_CICLOS, 1000, idle cycles in ENTRADA before the buffer is discarded.
- MAX_TENTATIVAS, 3, consecutive failures that trigger lockout.
- BLOQUEIO_CICLOS, 5000, lockout duration in cycles.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- tecla_value  input  4  decoded key code from the keypad decoder.
- tecla_valid  input  1  high while a debounced key is held.
- senha_ref  input  4*NUM_DIGITOS  reference code, nibble [3:0] = last digit; sampled in VERIFICAR.
- digitos  output  4*NUM_DIGITOS  entry buffer for display; newest digit in [3:0]; empty nibbles = 4'hF.
- num_digitos  output  4  count of digits entered (0..NUM_DIGITOS).
- acesso_ok  output  1  one-cycle pulse on a correct code.
- acesso_negado  output  1  one-cycle pulse on a wrong or incomplete code.
- bloqueado  output  1  high during lockout.
- ocupado  output  1  high in any state other than OCIOSO.

Behaviour:
- Reset: state OCIOSO, buffer all 4'hF, num_digitos=0, fail counter=0, timers=0, all pulses/flags 0.
- Key event: rising edge of tecla_valid, detected with a registered copy of tecla_valid. tecla_value is sampled in the same cycle as the edge.
  - A held key yields exactly one event.
  - The edge detector runs in every state. An edge arriving in a state that ignores keys is discarded, not queued.
- Key classes:
  - 0x0-0x9: digit.
  - 0xA: confirm.
  - 0xB: backspace.
  - 0xC: clear.
  - 0xD, 0xE, 0xF: ignored (no state change, no timer reset).
- OCIOSO:
  - Digit event: shift the digit in, num_digitos=1, go to ENTRADA.
  - Confirm with an empty buffer: go to FALHA.
  - All other keys: ignored.
- ENTRADA:
  - Digit: buffer <= {buffer[4*N-5:0], digit}, num_digitos+1. If already full, the digit is dropped.
  - Backspace: buffer <= {4'hF, buffer[4*N-1:4]}, num_digitos-1. If num_digitos reaches 0, go to OCIOSO.
  - Clear: buffer all F, count 0, go to OCIOSO.
  - Confirm: go to VERIFICAR.
  - Any non-ignored event restarts the idle counter.
  - Idle counter reaching TIMEOUT_CICLOS-1: clear buffer, go to OCIOSO, no pulse.
- VERIFICAR (1 cycle):
  - Match requires num_digitos==NUM_DIGITOS and buffer==senha_ref.
  - Match: go to SUCESSO. Otherwise: go to FALHA.
- SUCESSO (1 cycle): acesso_ok=1, fail counter=0, buffer cleared, go to OCIOSO.
- FALHA (1 cycle):
  - acesso_negado=1, fail counter+1, buffer cleared.
  - If the new count equals MAX_TENTATIVAS: go to BLOQUEIO and load the lockout timer. Otherwise: go to OCIOSO.
- BLOQUEIO:
  - bloqueado=1; all key events ignored.
  - After BLOQUEIO_CICLOS cycles: fail counter=0, go to OCIOSO.
- Outputs acesso_ok, acesso_negado, bloqueado and ocupado are registered and decoded from state, giving one cycle of latency after state entry.
- Timer widths are $clog2 of the respective parameter; no wrap is possible because the counters are cleared on state exit.
- rst asserted in any state returns immediately to reset values; a partial entry or lockout is lost.

Optional Feature:
- Macro: SENHA_MASCARADA_EN.
- Defined: each entered nibble in digitos reads 4'hE (masked); empty nibbles stay 4'hF. Comparison still uses the true digits.
- Undefined: digitos shows the real digit values.

Decomposition:
- Package pkg_teclado holds:
  - key-code constants TECLA_CONFIRMA=4'hA, TECLA_APAGA=4'hB, TECLA_LIMPA=4'hC, TECLA_NULA=4'hF;
  - the state enum {OCIOSO, ENTRADA, VERIFICAR, SUCESSO, FALHA, BLOQUEIO};
  - the helper function eh_digito().
- Sub-module temporizador_ciclos (load/clear, terminal-count flag), instantiated twice: idle timeout and lockout.

Test Plan:
1. senha_ref=16'h1234; keys 1,2,3,4,A, each held 5 cycles -> digitos passes 16'hFFF1 ... 16'h1234; acesso_ok one pulse 2 cycles after the A edge; num_digitos returns to 0.
2. Keys 1,2,5,B,3,4,A with ref 16'h1234 -> after B, digitos=16'hFF12, count 2; final acesso_ok=1.
3. Keys 9,9,A (incomplete) three times, MAX_TENTATIVAS=3 -> three acesso_negado pulses; bloqueado=1 for 5000 cycles; key 1 during lockout leaves digitos=16'hFFFF; afterwards OCIOSO with fail counter 0.
4. Key 7, then no input for 1000 cycles -> digitos back to 16'hFFFF, ocupado=0, no pulse. Key 7 again at cycle 999 -> buffer 16'hFF77, no timeout.
5. Key 5 held 200 cycles -> exactly one digit entered. Digits 1,2,3,4,5 -> fifth digit dropped, digitos=16'h1234.
6. rst pulsed mid-entry (buffer 16'hFF12) and mid-lockout -> all outputs return to reset values within the same cycle; next correct entry succeeds.
